// File: rtl/prbs_word_checker_pkg.sv
// Shared BERT definitions: checker states, PRBS7 taps and datapath widths.
// Used by the word checker, its bus interface and the word predictor.
package prbs_word_checker_pkg;

  localparam int WORD_W     = 8;
  localparam int CNT_W      = 32;
  localparam int SYNC_W     = 8;
  localparam int PRBS_ORDER = 7;

  // x^7 + x^6 + 1 : s[n] = s[n-7] ^ s[n-6]
  localparam int PRBS_TAP_A = 7;
  localparam int PRBS_TAP_B = 6;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } bert_state_e;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [PRBS_ORDER-1:0] prbs_state_t;
  typedef logic [CNT_W-1:0]      cnt_t;

endpackage

// File: rtl/prbs_word_checker_if.sv
// Word stream and BER readout bundle between the link side and the checker.
// master drives words/clear and observes results; slave is the checker.
interface prbs_word_checker_if;
  import prbs_word_checker_pkg::*;

  word_t             data_in;
  logic              data_valid;
  logic              clear;
  logic              locked;
  word_t             error;
  cnt_t              bit_count;
  cnt_t              error_count;
  logic [SYNC_W-1:0] sync_loss_count;

  modport master (
    output data_in, data_valid, clear,
    input  locked, error, bit_count, error_count, sync_loss_count
  );

  modport slave (
    input  data_in, data_valid, clear,
    output locked, error, bit_count, error_count, sync_loss_count
  );

endinterface

// File: rtl/prbs_word_checker_predict.sv
// PRBS7 8-bit unroll: predicts the next word (bit 7 earliest) from the last 7 bits; combinational.
// state bit 0 is the most recent sequence bit, so the next state is word_o[6:0].
module prbs7_word_predict
  import prbs_word_checker_pkg::*;
(
  input  prbs_state_t state_i,
  output word_t       word_o,
  output prbs_state_t state_o
);

  prbs_state_t st;
  logic        nb;

  always_comb begin
    st     = state_i;
    nb     = 1'b0;
    word_o = '0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      nb        = st[PRBS_TAP_A-1] ^ st[PRBS_TAP_B-1];
      word_o[i] = nb;
      st        = {st[PRBS_ORDER-2:0], nb};
    end
    state_o = st;
  end

endmodule

// File: rtl/prbs_word_checker.sv
// Self-synchronising PRBS7 word checker with saturating BER counters; all outputs registered, 1-cycle latency.
// No backpressure: a word is consumed on every edge where data_valid is high.
module prbs_word_checker
  import prbs_word_checker_pkg::*;
#(
  parameter int LOCK_WORDS   = 4,
  parameter int UNLOCK_WORDS = 4,
  parameter int UNLOCK_BITS  = 3
) (
  input logic                clk_i,
  input logic                rst_ni,
  prbs_word_checker_if.slave chk_if
);

  localparam int MW = $clog2(LOCK_WORDS + 1);
  localparam int BW = $clog2(UNLOCK_WORDS + 1);
  localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_WORDS - 1);
  localparam logic [BW-1:0] UNLOCK_LAST = BW'(UNLOCK_WORDS - 1);
  localparam logic [3:0]    UNLOCK_THR  = 4'(UNLOCK_BITS);

  bert_state_e       state_q,     state_d;
  prbs_state_t       lfsr_q,      lfsr_d;
  logic [MW-1:0]     match_cnt_q, match_cnt_d;
  logic [BW-1:0]     bad_cnt_q,   bad_cnt_d;
  logic              locked_q,    locked_d;
  word_t             error_q,     error_d;
  cnt_t              bit_cnt_q,   bit_cnt_d;
  cnt_t              err_cnt_q,   err_cnt_d;
  logic [SYNC_W-1:0] sync_loss_q, sync_loss_d;

  word_t             pred_word;
  prbs_state_t       pred_next;
  word_t             mismatch;
  logic [3:0]        popcnt;
  logic [CNT_W:0]    bit_sum;
  logic [CNT_W:0]    err_sum;

  prbs7_word_predict u_predict (
    .state_i (lfsr_q),
    .word_o  (pred_word),
    .state_o (pred_next)
  );

  assign mismatch = chk_if.data_in ^ pred_word;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < WORD_W; i++) begin
      popcnt = popcnt + 4'(mismatch[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    match_cnt_d = match_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    error_d     = '0;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    sync_loss_d = sync_loss_q;
    bit_sum     = {1'b0, bit_cnt_q} + (CNT_W+1)'(WORD_W);
    err_sum     = {1'b0, err_cnt_q} + (CNT_W+1)'(popcnt);

    if (chk_if.data_valid) begin
      unique case (state_q)
        ST_SEARCH: begin
          lfsr_d      = chk_if.data_in[PRBS_ORDER-1:0];
          match_cnt_d = '0;
          state_d     = ST_VERIFY;
        end
        ST_VERIFY: begin
          if (mismatch == '0) begin
            lfsr_d = pred_next;
            if (match_cnt_q == LOCK_LAST) begin
              match_cnt_d = '0;
              bad_cnt_d   = '0;
              state_d     = ST_LOCKED;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            lfsr_d      = chk_if.data_in[PRBS_ORDER-1:0];
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel on the prediction so line errors never reach the LFSR.
          lfsr_d    = pred_next;
          error_d   = mismatch;
          bit_cnt_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
          err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
          if (popcnt >= UNLOCK_THR) begin
            if (bad_cnt_q == UNLOCK_LAST) begin
              bad_cnt_d   = '0;
              state_d     = ST_SEARCH;
              sync_loss_d = (sync_loss_q == '1) ? sync_loss_q : sync_loss_q + 1'b1;
            end else begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end else begin
            bad_cnt_d = '0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    if (chk_if.clear) begin
      bit_cnt_d   = '0;
      err_cnt_d   = '0;
      sync_loss_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_SEARCH;
      lfsr_q      <= '0;
      match_cnt_q <= '0;
      bad_cnt_q   <= '0;
      locked_q    <= 1'b0;
      error_q     <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      sync_loss_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      match_cnt_q <= match_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      sync_loss_q <= sync_loss_d;
    end
  end

  assign chk_if.locked          = locked_q;
  assign chk_if.error           = error_q;
  assign chk_if.bit_count       = bit_cnt_q;
  assign chk_if.error_count     = err_cnt_q;
  assign chk_if.sync_loss_count = sync_loss_q;

endmodule

// File: tb/tb_prbs_word_checker.sv
// Directed bench for prbs_word_checker: lock, error masking, unlock/relock, clear, saturation, async reset.
module tb_prbs_word_checker;
  import prbs_word_checker_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [6:0] gen_hist = 7'h7F;
  logic [7:0] w;

  prbs_word_checker_if bus ();

  prbs_word_checker dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .chk_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial reference source: emits the next 8 sequence bits, earliest first.
  task automatic gen_word(output logic [7:0] word);
    logic b;
    word = '0;
    for (int i = 7; i >= 0; i--) begin
      b        = gen_hist[6] ^ gen_hist[5];
      word[i]  = b;
      gen_hist = {gen_hist[5:0], b};
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic clr);
    @(negedge clk);
    bus.data_in    = d;
    bus.data_valid = v;
    bus.clear      = clr;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.clear      = 1'b0;
  endtask

  initial begin
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.clear      = 1'b0;
    #1 rst_n = 1'b0;

    // Reset held while data_valid toggles
    for (int i = 0; i < 4; i++) begin
      drive(8'($urandom), i[0], 1'b0);
      check_val("rst_locked", 32'(bus.locked), 32'd0);
      check_val("rst_error", 32'(bus.error), 32'd0);
      check_val("rst_bits", bus.bit_count, 32'd0);
      check_val("rst_errs", bus.error_count, 32'd0);
      check_val("rst_state", 32'(dut.state_q), 32'(ST_SEARCH));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream: lock after word 5, then 10 counted words
    for (int k = 1; k <= 15; k++) begin
      gen_word(w);
      drive(w, 1'b1, 1'b0);
      if (k == 4) check_val("lock_w4", 32'(bus.locked), 32'd0);
      if (k == 5) begin
        check_val("lock_w5", 32'(bus.locked), 32'd1);
        check_val("lock_bits0", bus.bit_count, 32'd0);
      end
      if (k == 6) check_val("bits_w6", bus.bit_count, 32'd8);
    end
    check_val("clean_bits", bus.bit_count, 32'd80);
    check_val("clean_errs", bus.error_count, 32'd0);
    check_val("clean_error", 32'(bus.error), 32'd0);

    // Single flipped LSB, then clean word: no propagation
    gen_word(w);
    drive(w ^ 8'h01, 1'b1, 1'b0);
    check_val("flip_error", 32'(bus.error), 32'h01);
    check_val("flip_errs", bus.error_count, 32'd1);
    check_val("flip_locked", 32'(bus.locked), 32'd1);
    check_val("flip_bits", bus.bit_count, 32'd88);
    gen_word(w);
    drive(w, 1'b1, 1'b0);
    check_val("after_flip_error", 32'(bus.error), 32'h00);
    check_val("after_flip_errs", bus.error_count, 32'd1);

    // Clear on an idle cycle keeps lock
    drive(8'h00, 1'b0, 1'b1);
    check_val("idle_clr_bits", bus.bit_count, 32'd0);
    check_val("idle_clr_errs", bus.error_count, 32'd0);
    check_val("idle_clr_locked", 32'(bus.locked), 32'd1);

    // Four inverted words force loss of sync
    for (int k = 1; k <= 4; k++) begin
      gen_word(w);
      drive(~w, 1'b1, 1'b0);
      check_val("inv_error", 32'(bus.error), 32'hFF);
      if (k == 3) check_val("inv_locked_w3", 32'(bus.locked), 32'd1);
    end
    check_val("inv_locked_w4", 32'(bus.locked), 32'd0);
    check_val("inv_errs", bus.error_count, 32'd32);
    check_val("inv_bits", bus.bit_count, 32'd32);
    check_val("inv_sync_loss", 32'(bus.sync_loss_count), 32'd1);

    // Relock on the clean stream after 5 words; nothing counted meanwhile
    for (int k = 1; k <= 5; k++) begin
      gen_word(w);
      drive(w, 1'b1, 1'b0);
      if (k == 1) check_val("relock_error", 32'(bus.error), 32'h00);
      if (k == 4) check_val("relock_w4", 32'(bus.locked), 32'd0);
    end
    check_val("relock_w5", 32'(bus.locked), 32'd1);
    check_val("relock_bits", bus.bit_count, 32'd32);

    // Clear coincident with a 2-error word
    gen_word(w);
    drive(w ^ 8'h03, 1'b1, 1'b1);
    check_val("clr_bits", bus.bit_count, 32'd0);
    check_val("clr_errs", bus.error_count, 32'd0);
    check_val("clr_sync_loss", 32'(bus.sync_loss_count), 32'd0);
    check_val("clr_locked", 32'(bus.locked), 32'd1);
    check_val("clr_error", 32'(bus.error), 32'h03);

    // Gaps change nothing and error returns to 0
    for (int k = 0; k < 3; k++) begin
      drive(8'hA5, 1'b0, 1'b0);
      check_val("gap_bits", bus.bit_count, 32'd0);
      check_val("gap_error", 32'(bus.error), 32'h00);
    end
    gen_word(w);
    drive(w, 1'b1, 1'b0);
    check_val("post_gap_bits", bus.bit_count, 32'd8);
    check_val("post_gap_errs", bus.error_count, 32'd0);
    gen_word(w);
    drive(w ^ 8'h81, 1'b1, 1'b0);
    check_val("two_err_error", 32'(bus.error), 32'h81);
    check_val("two_err_errs", bus.error_count, 32'd2);
    check_val("two_err_bits", bus.bit_count, 32'd16);

    // Saturation of error_count
    @(negedge clk);
    force dut.err_cnt_q = 32'hFFFF_FFFA;
    @(negedge clk);
    release dut.err_cnt_q;
    gen_word(w);
    drive(~w, 1'b1, 1'b0);
    check_val("sat_errs", bus.error_count, 32'hFFFF_FFFF);
    gen_word(w);
    drive(w ^ 8'h10, 1'b1, 1'b0);
    check_val("sat_hold", bus.error_count, 32'hFFFF_FFFF);
    check_val("sat_locked", 32'(bus.locked), 32'd1);

    // Asynchronous reset mid-lock, sampled before the next clock edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_locked", 32'(bus.locked), 32'd0);
    check_val("arst_bits", bus.bit_count, 32'd0);
    check_val("arst_errs", bus.error_count, 32'd0);
    check_val("arst_state", 32'(dut.state_q), 32'(ST_SEARCH));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
